// File: rtl/max_unpool.sv
// Max-unpool: expands one (value, argmax) pair into WINDOW beats, value at argmax, zero elsewhere.
// Optional sticky out-of-range flag `err` is built when MAX_UNPOOL_ERR_EN is defined.
module max_unpool #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 4,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [IDX_W-1:0] in_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_pos,
  output logic             out_last
`ifdef MAX_UNPOOL_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic             out_last_q, out_last_d;
  logic             out_fire, in_fire;
  logic [IDX_W-1:0] pos_inc;

  assign out_valid = (state_q == EMIT);
  assign out_pos   = pos_q;
  assign out_value = out_value_q;
  assign out_last  = out_last_q;
  assign out_fire  = out_valid & out_ready;
  // Accepting on the last beat's handshake lets windows stream with no bubble.
  assign in_ready  = (state_q == IDLE) | (out_fire & out_last_q);
  assign in_fire   = in_valid & in_ready;
  assign pos_inc   = pos_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    index_d     = index_q;
    value_d     = value_q;
    out_value_d = out_value_q;
    out_last_d  = out_last_q;
    if (in_fire) begin
      state_d     = EMIT;
      pos_d       = '0;
      index_d     = in_index;
      value_d     = in_value;
      out_value_d = (in_index == '0) ? in_value : '0;
      out_last_d  = 1'b0;
    end else if (out_fire) begin
      if (out_last_q) begin
        state_d     = IDLE;
        pos_d       = '0;
        out_value_d = '0;
        out_last_d  = 1'b0;
      end else begin
        pos_d       = pos_inc;
        out_value_d = (pos_inc == index_q) ? value_q : '0;
        out_last_d  = (pos_inc == LAST_POS);
      end
    end
  end

`ifdef MAX_UNPOOL_ERR_EN
  localparam logic [IDX_W:0] WIN_EXT = (IDX_W + 1)'(WINDOW);
  logic err_q, err_d;
  assign err   = err_q;
  assign err_d = err_q | (in_fire & ({1'b0, in_index} >= WIN_EXT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      index_q     <= '0;
      value_q     <= '0;
      out_value_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      index_q     <= index_d;
      value_q     <= value_d;
      out_value_q <= out_value_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_max_unpool.sv
// Directed bench for max_unpool: hand-computed beat sequences for streaming, stall, range and reset cases.
module tb_max_unpool;

  localparam int W  = 32;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_value;
  logic [IW-1:0] in_index;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_value;
  logic [IW-1:0] out_pos;
  logic          out_last;
`ifdef MAX_UNPOOL_ERR_EN
  logic          err;
`endif

  int n_vec = 0;
  int n_err = 0;

  max_unpool #(.WIDTH(W), .WINDOW(4), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_index(in_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_pos(out_pos), .out_last(out_last)
`ifdef MAX_UNPOOL_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one input mid-cycle, confirm it is acceptable, drop valid after the accepting edge.
  task automatic send(input logic [W-1:0] v, input logic [IW-1:0] idx);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    in_index = idx;
    #1 chk("send_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic exp_beat(input string tag, input int pos, input logic [W-1:0] val,
                          input logic last, input logic rdy);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, W'(out_valid), W'(1));
    chk({tag, "_pos"},   W'(out_pos),   W'(pos));
    chk({tag, "_value"}, out_value,     val);
    chk({tag, "_last"},  W'(out_last),  W'(last));
    chk({tag, "_inrdy"}, W'(in_ready),  W'(rdy));
  endtask

  task automatic exp_idle(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_idle_valid"}, W'(out_valid), W'(0));
    chk({tag, "_idle_inrdy"}, W'(in_ready),  W'(1));
  endtask

  logic       bp_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int         bp_pos  [6] = '{0, 1, 1, 1, 2, 3};
  int         bp_val  [6] = '{0, 10, 10, 10, 0, 0};
  logic       bp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       bp_irdy [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    in_index  = '0;
    out_ready = 1'b1;

    // 1: reset
    #2;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_value", out_value, W'(0));
    #6;
    chk("rst_valid2", W'(out_valid), W'(0));
    chk("rst_pos", W'(out_pos), W'(0));
    chk("rst_last", W'(out_last), W'(0));
    #4 rst_n = 1'b1;
    #1 chk("rst_rel_inrdy", W'(in_ready), W'(1));
    chk("rst_rel_valid", W'(out_valid), W'(0));

    // 2: single window
    send(W'(20), 3'd2);
    exp_beat("t2b0", 0, W'(0), 1'b0, 1'b0);
    exp_beat("t2b1", 1, W'(0), 1'b0, 1'b0);
    exp_beat("t2b2", 2, W'(20), 1'b0, 1'b0);
    exp_beat("t2b3", 3, W'(0), 1'b1, 1'b1);
    exp_idle("t2");

    // 3: back-to-back, second input held until accepted on the last beat
    @(negedge clk);
    in_valid = 1'b1;
    in_value = W'(-3);
    in_index = 3'd0;
    @(posedge clk);
    #1;
    in_value = W'(35);
    in_index = 3'd3;
    exp_beat("t3b0", 0, W'(-3), 1'b0, 1'b0);
    exp_beat("t3b1", 1, W'(0), 1'b0, 1'b0);
    exp_beat("t3b2", 2, W'(0), 1'b0, 1'b0);
    exp_beat("t3b3", 3, W'(0), 1'b1, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    exp_beat("t3b4", 0, W'(0), 1'b0, 1'b0);
    exp_beat("t3b5", 1, W'(0), 1'b0, 1'b0);
    exp_beat("t3b6", 2, W'(0), 1'b0, 1'b0);
    exp_beat("t3b7", 3, W'(35), 1'b1, 1'b1);
    exp_idle("t3");

    // 4: backpressure
    send(W'(10), 3'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = bp_rdy[i];
      #1;
      chk("t4_valid", W'(out_valid), W'(1));
      chk("t4_pos",   W'(out_pos),   W'(bp_pos[i]));
      chk("t4_value", out_value,     W'(bp_val[i]));
      chk("t4_last",  W'(out_last),  W'(bp_last[i]));
      chk("t4_inrdy", W'(in_ready),  W'(bp_irdy[i]));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("t4_idle", W'(out_valid), W'(0));

    // 5: out-of-range index gives an all-zero window
    send(W'(7), 3'd5);
`ifdef MAX_UNPOOL_ERR_EN
    chk("t5_err_set", W'(err), W'(1));
`endif
    exp_beat("t5b0", 0, W'(0), 1'b0, 1'b0);
    exp_beat("t5b1", 1, W'(0), 1'b0, 1'b0);
    exp_beat("t5b2", 2, W'(0), 1'b0, 1'b0);
    exp_beat("t5b3", 3, W'(0), 1'b1, 1'b1);
    exp_idle("t5");
    send(W'(5), 3'd0);
    exp_beat("t5c0", 0, W'(5), 1'b0, 1'b0);
    exp_beat("t5c1", 1, W'(0), 1'b0, 1'b0);
    exp_beat("t5c2", 2, W'(0), 1'b0, 1'b0);
    exp_beat("t5c3", 3, W'(0), 1'b1, 1'b1);
`ifdef MAX_UNPOOL_ERR_EN
    chk("t5_err_sticky", W'(err), W'(1));
`endif
    exp_idle("t5c");

    // 6: asynchronous reset mid-window
    send(W'(5), 3'd3);
    exp_beat("t6b0", 0, W'(0), 1'b0, 1'b0);
    exp_beat("t6b1", 1, W'(0), 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", W'(out_valid), W'(0));
    chk("t6_rst_pos",   W'(out_pos),   W'(0));
    chk("t6_rst_last",  W'(out_last),  W'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("t6_rel_valid", W'(out_valid), W'(0));
`ifdef MAX_UNPOOL_ERR_EN
    chk("t6_err_clr", W'(err), W'(0));
`endif
    send(W'(0), 3'd0);
    exp_beat("t6c0", 0, W'(0), 1'b0, 1'b0);
    exp_beat("t6c1", 1, W'(0), 1'b0, 1'b0);
    exp_beat("t6c2", 2, W'(0), 1'b0, 1'b0);
    exp_beat("t6c3", 3, W'(0), 1'b1, 1'b1);
    exp_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
